// File: rtl/tank_select_encoder_f2_down_pkg.sv
// Shared tank-select definitions: FSM state encodings and tank-index width.
// The tank decoders reuse TankW.
package tank_select_encoder_f2_down_pkg;

    localparam int unsigned TankW = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StXfer = 2'd2
    } tank_sel_state_e;

endpackage

// File: rtl/tank_select_encoder_f2_down_slot_counter.sv
// Minor-cycle word-slot counter. major_sync forces slot 0 and takes priority
// over a coincident mc_pulse. slot_next/slot_tick let the initiator act on the
// slot value that this cycle's pulse is about to establish.
module tank_slot_counter #(
    parameter int unsigned WORD_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mc_pulse,
    input  logic              major_sync,
    output logic [WORD_W-1:0] slot,
    output logic [WORD_W-1:0] slot_next,
    output logic              slot_tick
);

    // Next slot value; wraps naturally at 2**WORD_W.
    always_comb begin
        slot_tick = mc_pulse | major_sync;
        slot_next = slot;
        if (major_sync) begin
            slot_next = '0;
        end else if (mc_pulse) begin
            slot_next = slot + WORD_W'(1);
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= '0;
        end else begin
            slot <= slot_next;
        end
    end

endmodule

// File: rtl/tank_select_encoder_f2_down.sv
// f2-down tank decoder initiator: latches a tank/word request, waits for the
// word slot to come round, then drives dual-rail address and t_in/t_out for
// exactly one minor cycle.
module tank_select_encoder_f2_down
    import tank_select_encoder_f2_down_pkg::*;
#(
    parameter int unsigned WORD_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mc_pulse,
    input  logic              major_sync,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TankW-1:0]  req_tank,
    input  logic [WORD_W-1:0] req_word,
    input  logic              req_write,
    output logic              f2_down_f7_pos,
    output logic              f2_down_f7_neg,
    output logic              f2_down_f8_pos,
    output logic              f2_down_f8_neg,
    output logic              f2_down_t_in,
    output logic              f2_down_t_out,
    output logic              busy,
    output logic              done
);

    tank_sel_state_e   state_q, state_d;
    logic [TankW-1:0]  tank_q, tank_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              write_q, write_d;
    logic              done_d;
    logic              f7_pos_d, f7_neg_d, f8_pos_d, f8_neg_d, t_in_d, t_out_d;
    logic              xfer_d;

    logic [WORD_W-1:0] slot;
    logic [WORD_W-1:0] slot_next;
    logic              slot_tick;

    tank_slot_counter #(
        .WORD_W (WORD_W)
    ) u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .mc_pulse   (mc_pulse),
        .major_sync (major_sync),
        .slot       (slot),
        .slot_next  (slot_next),
        .slot_tick  (slot_tick)
    );

    // Next state, request latch and registered-output next values.
    always_comb begin
        state_d = state_q;
        tank_d  = tank_q;
        word_d  = word_q;
        write_d = write_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tank_d  = req_tank;
                    word_d  = req_word;
                    write_d = req_write;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Coincidence is pulse-triggered: a slot already equal to the
                // target at accept waits a full circulation.
                if (slot_tick && (slot_next == word_q)) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (slot_tick) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        xfer_d   = (state_d == StXfer);
        f7_pos_d = xfer_d &  tank_d[0];
        f7_neg_d = xfer_d & ~tank_d[0];
        f8_pos_d = xfer_d &  tank_d[1];
        f8_neg_d = xfer_d & ~tank_d[1];
        t_in_d   = xfer_d &  write_d;
        t_out_d  = xfer_d & ~write_d;
    end

    // State, latch and output registers; reset aborts any transfer silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            tank_q         <= '0;
            word_q         <= '0;
            write_q        <= 1'b0;
            done           <= 1'b0;
            f2_down_f7_pos <= 1'b0;
            f2_down_f7_neg <= 1'b0;
            f2_down_f8_pos <= 1'b0;
            f2_down_f8_neg <= 1'b0;
            f2_down_t_in   <= 1'b0;
            f2_down_t_out  <= 1'b0;
        end else begin
            state_q        <= state_d;
            tank_q         <= tank_d;
            word_q         <= word_d;
            write_q        <= write_d;
            done           <= done_d;
            f2_down_f7_pos <= f7_pos_d;
            f2_down_f7_neg <= f7_neg_d;
            f2_down_f8_pos <= f8_pos_d;
            f2_down_f8_neg <= f8_neg_d;
            f2_down_t_in   <= t_in_d;
            f2_down_t_out  <= t_out_d;
        end
    end

    // Status decoded straight from the state register.
    always_comb begin
        busy      = (state_q != StIdle);
        req_ready = (state_q == StIdle);
    end

endmodule

// File: tb/tb_tank_select_encoder_f2_down.sv
// Self-checking bench for tank_select_encoder_f2_down. A behavioural model of
// the slot position and request lifecycle runs alongside the DUT.
module tb_tank_select_encoder_f2_down;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mc_pulse = 1'b0;
    logic       major_sync = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_tank = 2'd0;
    logic [4:0] req_word = 5'd0;
    logic       req_write = 1'b0;
    logic       req_ready;
    logic       f7p, f7n, f8p, f8n, t_in, t_out, busy, done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tank_select_encoder_f2_down #(
        .WORD_W (5)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mc_pulse       (mc_pulse),
        .major_sync     (major_sync),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_tank       (req_tank),
        .req_word       (req_word),
        .req_write      (req_write),
        .f2_down_f7_pos (f7p),
        .f2_down_f7_neg (f7n),
        .f2_down_f8_pos (f8p),
        .f2_down_f8_neg (f8n),
        .f2_down_t_in   (t_in),
        .f2_down_t_out  (t_out),
        .busy           (busy),
        .done           (done)
    );

    // Reference model: 0 idle, 1 waiting for slot, 2 transferring.
    int         m_phase = 0;
    int         m_slot = 0;
    int         m_word = 0;
    logic [1:0] m_tank = 2'd0;
    logic       m_write = 1'b0;
    logic       m_done = 1'b0;

    function automatic int next_slot(input int s, input logic mc, input logic ms);
        if (ms) return 0;
        if (mc) return (s + 1) % 32;
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_slot  <= 0;
            m_done  <= 1'b0;
        end else begin
            m_slot <= next_slot(m_slot, mc_pulse, major_sync);
            m_done <= 1'b0;
            if (m_phase == 0 && req_valid) begin
                m_phase <= 1;
                m_word  <= int'(req_word);
                m_tank  <= req_tank;
                m_write <= req_write;
            end else if (m_phase == 1 && (mc_pulse || major_sync) &&
                         next_slot(m_slot, mc_pulse, major_sync) == m_word) begin
                m_phase <= 2;
            end else if (m_phase == 2 && (mc_pulse || major_sync)) begin
                m_phase <= 0;
                m_done  <= 1'b1;
            end
        end
    end

    function automatic logic [8:0] exp_vec();
        logic x;
        x = (m_phase == 2);
        return {x & m_tank[0], x & ~m_tank[0], x & m_tank[1], x & ~m_tank[1],
                x & m_write, x & ~m_write, m_phase != 0, m_done, m_phase == 0};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {f7p, f7n, f8p, f8n, t_in, t_out, busy, done, req_ready};
    endfunction

    // Apply one cycle of inputs and advance to the following negedge.
    task automatic tick(input logic mc, input logic ms, input logic rv,
                        input logic [1:0] t, input logic [4:0] w, input logic wr);
        mc_pulse   = mc;
        major_sync = ms;
        req_valid  = rv;
        req_tank   = t;
        req_word   = w;
        req_write  = wr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'd1, 5'd1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        vectors++;
        if (t_in !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_setup_xfer: t_in=%b busy=%b, want t_in=1 busy=1", t_in, busy);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
            vectors++;
            if (dut_vec() !== 9'b000000001) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b, want 000000001", dut_vec());
            end
        end
        vectors++;
        if (u_dut.u_slot_counter.slot !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_slot: got %0d, want 0", u_dut.u_slot_counter.slot);
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        vectors++;
        if (dut_vec() !== 9'b000000001) begin
            miscompares++;
            $display("FAIL reset_release_no_done: got %b, want 000000001", dut_vec());
        end
    endtask

    // Read tank 2 word 5, mc_pulse every 4 clocks.
    task automatic test_read();
        int pulses = 0, strobe_cyc = 0, dones = 0, pulses_at_strobe = -1;
        tick(1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'd2, 5'd5, 1'b0);
        for (int i = 0; i < 80 && dones == 0; i++) begin
            logic mc;
            mc = (i % 4 == 3);
            if (mc) pulses++;
            tick(mc, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL read_cycle%0d: got %b, want %b", i, dut_vec(), exp_vec());
            end
            if (t_out) begin
                strobe_cyc++;
                if (pulses_at_strobe < 0) pulses_at_strobe = pulses;
            end
            if (done) dones++;
        end
        vectors++;
        if (pulses_at_strobe != 5) begin
            miscompares++;
            $display("FAIL read_strobe_pulse: got %0d, want 5", pulses_at_strobe);
        end
        vectors++;
        if (strobe_cyc != 4 || dones != 1) begin
            miscompares++;
            $display("FAIL read_width_done: width=%0d done=%0d, want 4 and 1", strobe_cyc, dones);
        end
        tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL read_done_single: got %b, want 0", done);
        end
    endtask

    // Write tank 3 word 31 with a random pulse period; XFER ends on the wrap.
    task automatic test_write31();
        int period, dones = 0, seen = 0;
        period = int'($urandom_range(1, 3));
        tick(1'b0, 1'b1, 1'b1, 2'd3, 5'd31, 1'b1);
        for (int i = 0; i < 200 && dones == 0; i++) begin
            tick((i % period) == 0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL write31_cycle%0d: got %b, want %b", i, dut_vec(), exp_vec());
            end
            if (t_in && seen == 0) begin
                seen = 1;
                vectors++;
                if ({f7p, f7n, f8p, f8n, t_out} !== 5'b10100 ||
                    u_dut.u_slot_counter.slot !== 5'd31) begin
                    miscompares++;
                    $display("FAIL write31_strobe: rails=%b slot=%0d, want 10100 slot 31",
                             {f7p, f7n, f8p, f8n, t_out}, u_dut.u_slot_counter.slot);
                end
            end
            if (done) dones++;
        end
        vectors++;
        if (dones != 1 || u_dut.u_slot_counter.slot !== 5'd0) begin
            miscompares++;
            $display("FAIL write31_wrap_done: done=%0d slot=%0d, want 1 and 0",
                     dones, u_dut.u_slot_counter.slot);
        end
    endtask

    // Accept word 7 while slot is already 7: a full circulation is needed.
    task automatic test_same_slot();
        int pulses = 0, got = -1;
        tick(1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'd1, 5'd7, 1'b0);
        for (int i = 0; i < 200 && got < 0; i++) begin
            logic mc;
            mc = (i % 2 == 1);
            if (mc) pulses++;
            tick(mc, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL same_slot_cycle%0d: got %b, want %b", i, dut_vec(), exp_vec());
            end
            if (t_out) got = pulses;
        end
        vectors++;
        if (got != 32) begin
            miscompares++;
            $display("FAIL same_slot_pulses: got %0d, want 32", got);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    endtask

    // major_sync and mc_pulse together while waiting for word 0.
    task automatic test_sync_coincident();
        tick(1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        vectors++;
        if (t_in !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_wait: t_in=%b busy=%b, want 0 1", t_in, busy);
        end
        tick(1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
        vectors++;
        if (dut_vec() !== 9'b010110100 || u_dut.u_slot_counter.slot !== 5'd0) begin
            miscompares++;
            $display("FAIL sync_xfer: got %b slot=%0d, want 010110100 slot 0",
                     dut_vec(), u_dut.u_slot_counter.slot);
        end
        tick(1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec() || done !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_done: got %b, want %b", dut_vec(), exp_vec());
        end
    endtask

    // Continuous random requests: accept in the done cycle, rails never 1/1.
    task automatic test_back_to_back();
        logic prev_done = 1'b0;
        int   completions = 0;
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0, 1'b1,
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got %b, want %b", i, dut_vec(), exp_vec());
            end
            if ((f7p && f7n) || (f8p && f8n) || (t_in && t_out)) begin
                miscompares++;
                $display("FAIL b2b_rails%0d: got %b, want no 1/1 pair", i, dut_vec());
            end
            if (prev_done && busy !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_no_gap%0d: busy=%b, want 1", i, busy);
            end
            if (done) completions++;
            prev_done = done;
        end
        vectors++;
        if (completions < 10) begin
            miscompares++;
            $display("FAIL b2b_completions: got %0d, want at least 10", completions);
        end
        tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
        test_reset();
        test_read();
        test_write31();
        test_same_slot();
        test_sync_coincident();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
